// File: rtl/wb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// wb_mem_arbiter
//
// Two-master, one-slave arbiter for the CPU memory bus. M0 is the
// instruction-fetch master (read only), M1 the load/store master. One master is
// granted at a time. The grant is held until the slave acknowledges. When both
// masters request, the grant alternates round-robin.
//
// Ports:
//   CLK_I, RST_I          clock (rising edge), synchronous active-high reset
//   M0_STB_I, M0_ADR_I    fetch request and address
//   M0_AKN_O, M0_DAT_O    fetch acknowledge and read data
//   M1_STB_I, M1_WE_I     data request, 1 = write
//   M1_ADR_I, M1_DAT_I    data address and write data
//   M1_AKN_O, M1_DAT_O    data acknowledge and read data
//   S_STB_O, S_WE_O       slave strobe and write enable
//   S_ADR_O, S_DAT_O      slave address and write data
//   S_DAT_I, S_AKN_I      slave read data and acknowledge
//   ERR_O                 one-cycle pulse when a granted transfer is aborted
//
// Build option:
//   WB_ARB_TIMEOUT_EN  when defined, a granted transfer that sees no S_AKN_I
//                      for TIMEOUT_CYC cycles is aborted and ERR_O pulses.
//                      When undefined, ERR_O is 0 and the grant is held until
//                      the slave acknowledges.
// -----------------------------------------------------------------------------
module wb_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              M0_STB_I,
    input  logic [ADDR_W-1:0] M0_ADR_I,
    output logic              M0_AKN_O,
    output logic [DATA_W-1:0] M0_DAT_O,
    input  logic              M1_STB_I,
    input  logic              M1_WE_I,
    input  logic [ADDR_W-1:0] M1_ADR_I,
    input  logic [DATA_W-1:0] M1_DAT_I,
    output logic              M1_AKN_O,
    output logic [DATA_W-1:0] M1_DAT_O,
    output logic              S_STB_O,
    output logic              S_WE_O,
    output logic [ADDR_W-1:0] S_ADR_O,
    output logic [DATA_W-1:0] S_DAT_O,
    input  logic [DATA_W-1:0] S_DAT_I,
    input  logic              S_AKN_I,
    output logic              ERR_O
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last_gnt, last_gnt_nxt;  // 0 = M0 was served last
    logic   abort;                    // granted transfer gave up waiting for S_AKN_I

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] cnt;
    logic             err_q;
    logic             gnt_stb;

    assign gnt_stb = ((state == GNT0) && M0_STB_I) || ((state == GNT1) && M1_STB_I);

    // An ack in the final cycle still completes the transfer normally.
    assign abort = gnt_stb && !S_AKN_I && (cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Counter is held at zero in IDLE, so every grant starts counting from 0.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= abort;
            cnt   <= (state == IDLE) ? '0 : cnt + 1'b1;
        end
    end

    assign ERR_O = err_q;
`else
    assign abort = 1'b0;
    // Tied low; the timeout length only matters when the timeout logic is built.
    assign ERR_O = 1'b0 & (TIMEOUT_CYC != 0);
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state    <= IDLE;
            last_gnt <= 1'b1;  // M0 wins the first tie after reset
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    // Next-state logic.
    // NOTE: every variable is given a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        unique case (state)
            IDLE: begin
                if (M0_STB_I && M1_STB_I) state_nxt = last_gnt ? GNT0 : GNT1;
                else if (M0_STB_I)        state_nxt = GNT0;
                else if (M1_STB_I)        state_nxt = GNT1;
            end
            GNT0: begin
                // A master that withdraws its request releases the bus without
                // counting as served.
                if (!M0_STB_I) begin
                    state_nxt = IDLE;
                end else if (S_AKN_I || abort) begin
                    state_nxt    = IDLE;
                    last_gnt_nxt = 1'b0;
                end
            end
            GNT1: begin
                if (!M1_STB_I) begin
                    state_nxt = IDLE;
                end else if (S_AKN_I || abort) begin
                    state_nxt    = IDLE;
                    last_gnt_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Slave-side muxing and acknowledge path, combinational from state.
    // Acks are suppressed while RST_I is high so a transfer cut off by reset
    // never completes at the master.
    always_comb begin
        S_STB_O  = 1'b0;
        S_WE_O   = 1'b0;
        S_ADR_O  = '0;
        S_DAT_O  = '0;
        M0_AKN_O = 1'b0;
        M0_DAT_O = '0;
        M1_AKN_O = 1'b0;
        M1_DAT_O = '0;
        unique case (state)
            GNT0: begin
                S_STB_O  = M0_STB_I;
                S_ADR_O  = M0_ADR_I;
                M0_AKN_O = S_AKN_I && M0_STB_I && !RST_I;
                M0_DAT_O = S_DAT_I;
            end
            GNT1: begin
                S_STB_O  = M1_STB_I;
                S_WE_O   = M1_WE_I;
                S_ADR_O  = M1_ADR_I;
                S_DAT_O  = M1_DAT_I;
                M1_AKN_O = S_AKN_I && M1_STB_I && !RST_I;
                M1_DAT_O = S_DAT_I;
            end
            default: ;
        endcase
    end

endmodule
